jtag_mem_bridge: RTL

//  Downstream consumer of the virtual-JTAG strobes (WE/WE_LEN/WE_A, ADDR, WD, RD).

---
 rtl/jtag_mem_pkg.sv | 21 ++
 rtl/jtag_mem_bridge_buf_ram.sv | 40 ++++
 rtl/jtag_mem_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/jtag_mem_pkg.sv
// Shared definitions for the JTAG memory bridge: FSM state encoding,
// register-map addresses and command-word bit positions.
package jtag_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RD
  } state_t;

  // Host register map (ADDR[7] = 1 selects the register space)
  localparam logic [7:0] REG_STATUS = 8'h80;
  localparam logic [7:0] REG_START  = 8'h81;

  // Command word written with WE_LEN
  localparam int CMD_DIR_BIT = 31;  // 1 = buffer -> SDRAM
  localparam int CMD_CLR_BIT = 30;  // clear ERR only, no launch
  localparam int CMD_LEN_W   = 7;   // WD[6:0] = length - 1

endpackage

// File: rtl/jtag_mem_bridge_buf_ram.sv
// buf_ram: 2**AW x 32 word buffer with two synchronous-read ports.
//   clk, rst       : clock, synchronous active-high reset (read registers only)
//   a_we/a_addr/a_wd/a_rdata : port A, read/write, read data one cycle later
//   b_re/b_addr/b_rdata      : port B, read-only, read data held when b_re=0
module buf_ram #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wd,
  output logic [31:0]   a_rdata,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the
  // read-data registers are cleared.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wd;
  end

  // Port A returns the old word on a same-cycle write (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) a_rdata <= '0;
    else     a_rdata <= mem[a_addr];
  end

  // Port B only updates on a fetch so its output can drive MEM_WD directly
  // and stay stable for the whole request.
  always_ff @(posedge clk) begin
    if (rst)       b_rdata <= '0;
    else if (b_re) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/jtag_mem_bridge.sv
// jtag_mem_bridge: host (virtual JTAG) access to a word buffer, plus a burst
// engine that copies bursts between the buffer and an SDRAM word port.
//   CLK, RESET              : clock, synchronous active-high reset
//   WE, WE_A, WE_LEN        : host strobes (buffer write, start address, command)
//   ADDR, WD, RD            : host word index, write data, registered read data
//   MEM_REQ/WE/A/WD, MEM_ACK: request handshake to the SDRAM controller
//   MEM_RD, MEM_RVALID      : read data return, one per accepted read
module jtag_mem_bridge
  import jtag_mem_pkg::*;
#(
  parameter int MEM_AW = 24,
  parameter int BUF_AW = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic              WE_A,
  input  logic              WE_LEN,
  input  logic [7:0]        ADDR,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [MEM_AW-1:0] MEM_A,
  output logic [31:0]       MEM_WD,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RD,
  input  logic              MEM_RVALID
);

  state_t                 state_q, state_d;
  logic                   dir_q;
  logic [CMD_LEN_W-1:0]   len_m1_q;
  logic [7:0]             done_cnt_q;
  logic [BUF_AW-1:0]      idx_q;
  logic [MEM_AW-1:0]      waddr_q, start_q;
  logic                   err_q;
  logic                   rd_is_reg_q;
  logic [31:0]            rd_reg_q;

  logic                   busy, launch, last_word, ack_fire, rd_fire, word_done;
  logic                   err_set, err_clr, fetch_re;
  logic                   a_we;
  logic [BUF_AW-1:0]      a_addr;
  logic [31:0]            a_wd, a_rdata, b_rdata, reg_rdata, start_ext;

  assign busy      = (state_q != S_IDLE);
  // WE_A together with WE_LEN is an error case and never launches.
  assign launch    = !busy && WE_LEN && !WE_A && !WD[CMD_CLR_BIT];
  assign last_word = (done_cnt_q == {1'b0, len_m1_q});
  assign ack_fire  = (state_q == S_ISSUE) && MEM_ACK;
  assign rd_fire   = (state_q == S_WAIT_RD) && MEM_RVALID;
  assign word_done = (ack_fire && dir_q) || rd_fire;
  assign err_set   = (busy && (WE || WE_A || WE_LEN)) || (WE_A && WE_LEN) ||
                     (MEM_RVALID && (state_q != S_WAIT_RD));
  assign err_clr   = !busy && WE_LEN && !WE_A && WD[CMD_CLR_BIT];

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    MEM_REQ  = 1'b0;
    fetch_re = 1'b0;
    unique case (state_q)
      S_IDLE:    if (launch) state_d = WD[CMD_DIR_BIT] ? S_FETCH : S_ISSUE;
      S_FETCH: begin
        fetch_re = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK) begin
          if (!dir_q)         state_d = S_WAIT_RD;
          else if (last_word) state_d = S_IDLE;
          else                state_d = S_FETCH;
        end
      end
      S_WAIT_RD: if (MEM_RVALID) state_d = last_word ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_q      <= 1'b0;
      len_m1_q   <= '0;
      done_cnt_q <= '0;
      idx_q      <= '0;
      waddr_q    <= '0;
      start_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!busy && WE_A) start_q <= WD[MEM_AW-1:0];
      if (launch) begin
        dir_q      <= WD[CMD_DIR_BIT];
        len_m1_q   <= WD[CMD_LEN_W-1:0];
        done_cnt_q <= '0;
        idx_q      <= '0;
        waddr_q    <= start_q;
      end
      // Word address moves on at acceptance; it is only observed with MEM_REQ.
      if (ack_fire) waddr_q <= waddr_q + MEM_AW'(1);
      if (word_done) begin
        done_cnt_q <= done_cnt_q + 8'd1;
        idx_q      <= idx_q + BUF_AW'(1);
      end
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign MEM_WE = dir_q;
  assign MEM_A  = waddr_q;
  assign MEM_WD = b_rdata;

  // Port A belongs to the host while idle and to returning read data while
  // busy. A host buffer read in the same cycle as a returning word sees the
  // word at the burst index instead.
  always_comb begin
    a_we   = busy ? rd_fire : (WE && !ADDR[7]);
    a_addr = rd_fire ? idx_q : ADDR[BUF_AW-1:0];
    a_wd   = busy ? MEM_RD : WD;
  end

  always_comb begin
    start_ext                = '0;
    start_ext[MEM_AW-1:0]    = start_q;
    reg_rdata                = '0;
    case (ADDR)
      REG_STATUS: reg_rdata = {busy, err_q, 22'b0, done_cnt_q};
      REG_START:  reg_rdata = start_ext;
      default:    reg_rdata = '0;
    endcase
  end

  // Register reads are captured alongside the buffer's synchronous read so
  // both paths have the same one-cycle latency; reset selects the zero value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_is_reg_q <= 1'b1;
      rd_reg_q    <= '0;
    end else begin
      rd_is_reg_q <= ADDR[7];
      rd_reg_q    <= reg_rdata;
    end
  end

  assign RD = rd_is_reg_q ? rd_reg_q : a_rdata;

  buf_ram #(.AW(BUF_AW)) u_buf (
    .clk     (CLK),
    .rst     (RESET),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wd    (a_wd),
    .a_rdata (a_rdata),
    .b_re    (fetch_re),
    .b_addr  (idx_q),
    .b_rdata (b_rdata)
  );

endmodule
